module_bin2bcd_seq: RTL and testbench
=====================================

MODULE_BIN2BCD_SEQ -- requirements
Module: module_bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16: width of the signed two's-complement product from the Booth multiplier.
REQ-002 Parameter DIGITS, default 5: BCD digit count; SHALL satisfy 10^DIGITS > 2^(WIDTH-1).
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 start  input  1: conversion request, driven by the multiplier's done pulse.
REQ-006 product  input  WIDTH: signed product; sampled only when a start is accepted.
REQ-007 bcd  output  4*DIGITS: magnitude in BCD; digit 0 in bits [3:0].
REQ-008 sign  output  1: 1 = product was negative.
REQ-009 busy  output  1: high while a conversion is in progress.
REQ-010 valid  output  1: single-cycle pulse marking new bcd/sign.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, ADJ, SHIFT and DONE; the state is registered, with combinational next-state logic.
REQ-012 IDLE -> LOAD when start=1; otherwise stay in IDLE.
REQ-013 LOAD (1 cycle): capture sign = product[WIDTH-1]; load the shift register with the unsigned WIDTH-bit magnitude (negate if negative); clear the BCD scratch register; clear the iteration counter.
REQ-014 ADJ (1 cycle): add 3 to each scratch digit whose value is >= 5; go to SHIFT.
REQ-015 SHIFT (1 cycle): shift {scratch, magnitude} left by 1 and increment the counter; go to DONE when the counter reaches WIDTH, else go to ADJ.
REQ-016 DONE (1 cycle): copy scratch to bcd, assert valid, then return to IDLE.
REQ-017 Latency: valid SHALL be high in the (2*WIDTH+2)th cycle after the start-sampling edge, which is cycle 34 for WIDTH=16; the next start is accepted in the following cycle.
REQ-018 busy = 1 in the LOAD, ADJ, SHIFT and DONE states; busy = 0 in IDLE.
REQ-019 A start seen while the FSM is outside IDLE SHALL be ignored; it is neither queued nor allowed to alter the conversion in progress.
REQ-020 bcd and sign SHALL hold their last completed result until the next DONE; intermediate scratch values never appear on bcd.
REQ-021 sign is registered at LOAD but SHALL be presented together with bcd; the sign output updates only in DONE.
REQ-022 The most-negative input 2^(WIDTH-1) SHALL convert to its full magnitude (0x8000 -> 32768) without overflow.
REQ-023 A zero input SHALL give sign=0 and bcd all zeros.
REQ-024 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a conversion.
REQ-025 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-026 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL be bcd=0, sign=0, busy=0, valid=0.
REQ-027 When rst=1 mid-conversion, the conversion SHALL be aborted with no valid pulse, and no earlier result is retained.
REQ-028 rst SHALL take priority over start in the same cycle.

Verification
REQ-029 product=0x3039 with 1-cycle start -> cycle 34: valid=1, bcd=0x12345, sign=0; busy high in cycles 1-34.
REQ-030 product=0xFFFF -> sign=1, bcd=0x00001; product=0x0000 -> sign=0, bcd=0x00000.
REQ-031 product=0x8000 -> sign=1, bcd=0x32768; product=0x7FFF -> sign=0, bcd=0x32767.
REQ-032 start held high for 40 cycles with product changing at cycle 5 -> first result reflects the cycle-0 product; a second conversion starts at cycle 35.
REQ-033 rst asserted at cycle 10 of a conversion -> next cycle busy=0, bcd=0, no valid pulse; a new start then converts correctly.
REQ-034 Back-to-back: 12345 then -1 (second start at cycle 35) -> valid pulses at cycles 34 and 69 with the correct results; bcd is stable between the pulses.

Source files
------------

// File: rtl/module_bin2bcd_seq.sv
// Sequential signed binary to BCD converter (shift-and-add-3).
// Converts a signed product into sign plus BCD magnitude.
module module_bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      product,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  busy,
  output logic                  valid
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADJ   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    scratch_adj;
  logic [BW-1:0]    scratch_shl;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // State register; odd encodings fall back to IDLE via next-state.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = ADJ;
      ADJ:     state_nxt = SHIFT;
      SHIFT:   state_nxt = last ? DONE : ADJ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  // Add 3 to every digit >= 5 and form the shifted scratch.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_shl = {scratch[BW-2:0], mag[WIDTH-1]};
  end

  // Datapath; result registers load on the final shift so that
  // bcd/sign are presented together with valid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      bcd     <= '0;
      sign    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) prod_q <= product;
        end
        LOAD: begin
          sign_q  <= prod_q[WIDTH-1];
          mag     <= prod_q[WIDTH-1] ? -prod_q : prod_q;
          scratch <= '0;
          cnt     <= '0;
        end
        ADJ: begin
          scratch <= scratch_adj;
        end
        SHIFT: begin
          scratch <= scratch_shl;
          mag     <= {mag[WIDTH-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
          if (last) begin
            bcd  <= scratch_shl;
            sign <= sign_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_bin2bcd_seq.sv
// Self-checking bench for module_bin2bcd_seq.
// Directed vectors with hand-computed BCD results.
module tb_module_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] product;
  logic [19:0] bcd;
  logic        sign;
  logic        busy;
  logic        valid;

  int n_cmp = 0;
  int n_bad = 0;

  module_bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .product (product),
    .bcd     (bcd),
    .sign    (sign),
    .busy    (busy),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0), follow to cycle 35.
  task automatic convert(input string tag, input logic [15:0] p,
                         input logic [19:0] eb, input logic es);
    int n;
    bit busy_ok;
    bit hold_ok;
    logic [19:0] prev;
    prev = bcd;
    start = 1'b1;
    product = p;
    tick();
    start = 1'b0;
    product = ~p;
    n = 1;
    busy_ok = 1;
    hold_ok = 1;
    while (!valid && n < 100) begin
      if (!busy) busy_ok = 0;
      if (bcd !== prev) hold_ok = 0;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 34);
    chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, eb});
    chk({tag, "_sign"}, {31'd0, sign}, {31'd0, es});
    chk({tag, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
    chk({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    tick();
    chk({tag, "_post"}, {30'd0, busy, valid}, 32'd0);
    chk({tag, "_keep"}, {11'd0, sign, bcd}, {11'd0, es, eb});
  endtask

  initial begin
    int nv;
    int v1;
    int v2;
    logic [19:0] b1;
    logic [19:0] b2;
    rst = 1'b1;
    start = 1'b0;
    product = 16'h0;
    repeat (2) tick();
    chk("rst_out", {10'd0, bcd, sign, busy, valid}, 32'd0);
    rst = 1'b0;
    tick();

    convert("p12345", 16'h3039, 20'h12345, 1'b0);
    convert("pm1", 16'hFFFF, 20'h00001, 1'b1);
    convert("p0", 16'h0000, 20'h00000, 1'b0);
    convert("pmin", 16'h8000, 20'h32768, 1'b1);
    convert("pmax", 16'h7FFF, 20'h32767, 1'b0);
    convert("pm999", 16'hFC19, 20'h00999, 1'b1);

    // Start held 40 cycles, product changes at cycle 5.
    start = 1'b1;
    product = 16'd1000;
    nv = 0;
    v1 = 0;
    v2 = 0;
    b1 = '0;
    b2 = '0;
    for (int c = 1; c <= 75; c++) begin
      tick();
      if (c == 5) product = 16'd777;
      if (c == 40) start = 1'b0;
      if (valid) begin
        nv++;
        if (nv == 1) begin v1 = c; b1 = bcd; end
        if (nv == 2) begin v2 = c; b2 = bcd; end
      end
    end
    chk("hold_npulse", nv, 2);
    chk("hold_v1", v1, 34);
    chk("hold_b1", {12'd0, b1}, 32'h01000);
    chk("hold_v2", v2, 69);
    chk("hold_b2", {12'd0, b2}, 32'h00777);

    // Make the held result signed and nonzero before the abort.
    convert("pm5", 16'hFFFB, 20'h00005, 1'b1);

    // Reset at cycle 10 aborts the conversion.
    start = 1'b1;
    product = 16'h3039;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    chk("abort_out", {10'd0, bcd, sign, busy, valid}, 32'd0);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid || busy) nv++;
      tick();
    end
    chk("abort_quiet", nv, 0);

    // Reset wins over start in the same cycle.
    rst = 1'b1;
    start = 1'b1;
    product = 16'd42;
    tick();
    start = 1'b0;
    chk("rst_prio", {30'd0, busy, valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_prio_idle", {31'd0, busy}, 32'd0);

    convert("again", 16'h3039, 20'h12345, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
